// File: rtl/instr_issue_queue.sv
// instr_issue_queue: FIFO of instruction words issued one at a time to the control FSM with a run pulse and done handshake
module instr_issue_queue #(
  parameter int DATA_W = 8,
  parameter int FUNC_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      instr_valid,
  input  logic [FUNC_W+3+DATA_W-1:0] instr_data,
  output logic                      instr_ready,
  output logic [FUNC_W-1:0]         func,
  output logic [2:0]                input1,
  output logic [DATA_W-1:0]         input2,
  output logic                      run,
  input  logic                      done,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    level,
  output logic [7:0]                issued_cnt
);
  localparam int IW = FUNC_W + 3 + DATA_W;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state;
  logic [IW-1:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [IW-1:0] head_word;
  logic push, pop;
  assign instr_ready = !reset && (level != LW'(DEPTH));
  assign push = instr_valid && instr_ready;
  assign pop = (state == WAIT) && done;
  assign busy = (state != IDLE);
  assign head_word = mem[head];
  always_ff @(posedge clk)
    if (push) mem[tail] <= instr_data;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      level <= '0;
      state <= IDLE;
      run <= 1'b0;
      func <= '0;
      input1 <= '0;
      input2 <= '0;
      issued_cnt <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop) head <= head + AW'(1);
      level <= level + LW'(push) - LW'(pop);
      run <= 1'b0;
      case (state)
        IDLE: if (level != '0) begin
          state <= ISSUE;
          run <= 1'b1;
          func <= head_word[IW-1 -: FUNC_W];
          input1 <= head_word[DATA_W+2 -: 3];
          input2 <= head_word[DATA_W-1:0];
        end
        ISSUE: state <= WAIT;
        WAIT: if (done) begin
          state <= IDLE;
          issued_cnt <= issued_cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_issue_queue.sv
// tb_instr_issue_queue: directed and random stimulus against a queue-based reference model
module tb_instr_issue_queue;
  localparam int DATA_W = 8;
  localparam int FUNC_W = 2;
  localparam int DEPTH = 4;
  localparam int IW = FUNC_W + 3 + DATA_W;
  logic clk = 0;
  logic reset = 1;
  logic instr_valid = 0;
  logic [IW-1:0] instr_data = '0;
  logic instr_ready;
  logic [FUNC_W-1:0] func;
  logic [2:0] input1;
  logic [DATA_W-1:0] input2;
  logic run;
  logic done = 0;
  logic busy;
  logic [$clog2(DEPTH):0] level;
  logic [7:0] issued_cnt;
  int checks = 0;
  int errors = 0;
  logic [IW-1:0] q[$];
  int phase = 0;
  logic [IW-1:0] cur = '0;
  logic [7:0] cnt = '0;
  int completions = 0;

  instr_issue_queue #(.DATA_W(DATA_W), .FUNC_W(FUNC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_data(instr_data),
    .instr_ready(instr_ready), .func(func), .input1(input1), .input2(input2),
    .run(run), .done(done), .busy(busy), .level(level), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".run"}, 32'(run), 32'(phase == 1));
    chk({tag, ".busy"}, 32'(busy), 32'(phase != 0));
    chk({tag, ".level"}, 32'(level), 32'(q.size()));
    chk({tag, ".ready"}, 32'(instr_ready), 32'(!reset && q.size() != DEPTH));
    chk({tag, ".func"}, 32'(func), 32'(cur[IW-1 -: FUNC_W]));
    chk({tag, ".input1"}, 32'(input1), 32'(cur[DATA_W+2 -: 3]));
    chk({tag, ".input2"}, 32'(input2), 32'(cur[DATA_W-1:0]));
    chk({tag, ".cnt"}, 32'(issued_cnt), 32'(cnt));
  endtask

  task automatic model_reset();
    q.delete();
    phase = 0;
    cur = '0;
    cnt = '0;
    completions = 0;
  endtask

  // One clock: inputs applied before the edge, model stepped on the edge, outputs checked at negedge.
  task automatic cyc(input string tag, input logic v, input logic d, input logic [IW-1:0] w);
    bit acc, rel;
    instr_valid = v;
    done = d;
    instr_data = w;
    @(posedge clk);
    acc = v && q.size() != DEPTH;
    rel = phase == 2 && d;
    if (phase == 0 && q.size() != 0) begin
      phase = 1;
      cur = q[0];
    end else if (phase == 1) phase = 2;
    else if (rel) begin
      phase = 0;
      cnt = cnt + 8'd1;
      completions++;
    end
    if (rel) void'(q.pop_front());
    if (acc) q.push_back(w);
    @(negedge clk);
    chk_all(tag);
  endtask

  initial begin
    logic [IW-1:0] wa;
    int n;
    #1;
    model_reset();
    chk_all("por");
    @(negedge clk);
    reset = 0;
    #1 chk("por_release.ready", 32'(instr_ready), 32'd1);
    // Reset mid-WAIT with three words queued
    cyc("t1.push", 1, 0, 13'h0111);
    cyc("t1.push", 1, 0, 13'h0222);
    cyc("t1.push", 1, 0, 13'h0333);
    for (int i = 0; i < 3; i++) cyc("t1.idle", 0, 0, '0);
    chk("t1.level3", 32'(level), 32'd3);
    chk("t1.busy", 32'(busy), 32'd1);
    #2 reset = 1;
    #1;
    model_reset();
    chk_all("t1.reset");
    @(negedge clk);
    reset = 0;
    #1 chk("t1.release.ready", 32'(instr_ready), 32'd1);
    // Single word, long wait without done
    wa = {2'b01, 3'd5, 8'hA3};
    cyc("t2.push", 1, 0, wa);
    cyc("t2.issue", 0, 0, '0);
    chk("t2.run", 32'(run), 32'd1);
    chk("t2.word", 32'({func, input1, input2}), 32'(wa));
    for (int i = 0; i < 10; i++) cyc("t2.hold", 0, 0, '0);
    chk("t2.norun", 32'(run), 32'd0);
    cyc("t2.done", 0, 1, '0);
    cyc("t2.idle", 0, 0, '0);
    // Fill to full while first word waits
    for (int i = 0; i < 4; i++) cyc("t3.fill", 1, 0, IW'(13'h1A0 + i));
    cyc("t3.refuse", 1, 0, 13'h1FFF);
    chk("t3.full", 32'(level), 32'd4);
    chk("t3.notready", 32'(instr_ready), 32'd0);
    chk("t3.head", 32'({func, input1, input2}), 32'(13'h1A0));
    // Pop while full: push refused that cycle, accepted next
    cyc("t4.pop", 1, 1, 13'h0ABC);
    chk("t4.level3", 32'(level), 32'd3);
    cyc("t4.accept", 1, 0, 13'h0ABC);
    chk("t4.level4", 32'(level), 32'd4);
    n = 0;
    while (q.size() != 0 && n < 200) begin
      cyc("t4.drain", 0, phase == 2, '0);
      n++;
    end
    chk("t4.drained", 32'(level), 32'd0);
    // done asserted only during the ISSUE cycle must be ignored
    cyc("t5.push", 1, 0, 13'h15A5);
    for (int i = 0; i < 6; i++) cyc("t5.issue_done", 0, phase == 1, '0);
    chk("t5.still_wait", 32'(busy), 32'd1);
    cyc("t5.done", 0, 1, '0);
    // Random traffic until 257 completions since reset
    n = 0;
    while (completions < 257 && n < 20000) begin
      cyc("t6.rand", 1'($urandom), 1'($urandom), IW'($urandom));
      n++;
    end
    chk("t6.budget", 32'(completions), 32'd257);
    chk("t6.wrap", 32'(issued_cnt), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
